// File: rtl/exec_stage_pipe.sv
// Execute stage: operand forwarding, single-cycle/multicycle issue and an
// elastic output register feeding the downstream stage.
module exec_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_ID_W  = 5,
  parameter int T_W       = 4,
  parameter int NUM_FWD   = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                      Clk,
  input  logic                      Clr,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ID_W-1:0]       in_rs_id,
  input  logic [REG_ID_W-1:0]       in_rt_id,
  input  logic [REG_ID_W-1:0]       in_reg_id,
  input  logic [DATA_W-1:0]         in_rs_data,
  input  logic [DATA_W-1:0]         in_rt_data,
  input  logic [T_W-1:0]            in_t,
  input  logic                      in_wen,
  input  logic                      in_multi,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_wen,
  input  logic [NUM_FWD*T_W-1:0]    fwd_t,
  input  logic [NUM_FWD*REG_ID_W-1:0] fwd_reg_id,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         op_rs,
  output logic [DATA_W-1:0]         op_rt,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      xalu_start,
  output logic                      xalu_cancel,
  input  logic                      xalu_done,
  input  logic [DATA_W-1:0]         xalu_result,
  output logic                      out_valid,
  output logic                      out_wen,
  input  logic                      out_ready,
  output logic [T_W-1:0]            out_t,
  output logic [REG_ID_W-1:0]       out_reg_id,
  output logic [DATA_W-1:0]         out_data,
  output logic [DATA_W-1:0]         out_store_data,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, WAIT_X, DONE_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_valid_p1;
  logic                  r_wen_p1;
  logic [T_W-1:0]        r_t_p1;
  logic [REG_ID_W-1:0]   r_reg_id_p1;
  logic [DATA_W-1:0]     r_data_p1;
  logic [DATA_W-1:0]     r_store_p1;
  logic [PAYLOAD_W-1:0]  r_payload_p1;

  logic                  r_hold_wen;
  logic [T_W-1:0]        r_hold_t;
  logic [REG_ID_W-1:0]   r_hold_reg_id;
  logic [DATA_W-1:0]     r_hold_store;
  logic [PAYLOAD_W-1:0]  r_hold_payload;
  logic [DATA_W-1:0]     r_hold_result;

  logic                  w_advance;
  logic                  w_acc_single;
  logic                  w_acc_multi;
  logic                  w_x_finish;
  logic                  w_own_ok;
  logic [T_W-1:0]        w_t_dec;

  // Lowest priority source is applied first so later (higher priority) hits override.
  function automatic logic [DATA_W-1:0] f_fwd(
    input logic [REG_ID_W-1:0]         id,
    input logic [DATA_W-1:0]           rf,
    input logic                        own_ok,
    input logic [REG_ID_W-1:0]         own_id,
    input logic [DATA_W-1:0]           own_data,
    input logic [NUM_FWD-1:0]          v,
    input logic [NUM_FWD-1:0]          w,
    input logic [NUM_FWD*T_W-1:0]      t,
    input logic [NUM_FWD*REG_ID_W-1:0] rid,
    input logic [NUM_FWD*DATA_W-1:0]   d
  );
    logic [DATA_W-1:0] res;
    res = rf;
    if (id != '0) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (v[k] && w[k] && (t[k*T_W +: T_W] == '0) &&
            (rid[k*REG_ID_W +: REG_ID_W] == id))
          res = d[k*DATA_W +: DATA_W];
      end
      if (own_ok && (own_id == id))
        res = own_data;
    end
    return res;
  endfunction

  assign w_advance = !r_valid_p1 || out_ready;
  assign w_own_ok  = r_valid_p1 && r_wen_p1 && (r_t_p1 == '0);
  assign w_t_dec   = (in_t == '0) ? '0 : in_t - T_W'(1);

  assign op_rs = f_fwd(in_rs_id, in_rs_data, w_own_ok, r_reg_id_p1, r_data_p1,
                       fwd_valid, fwd_wen, fwd_t, fwd_reg_id, fwd_data);
  assign op_rt = f_fwd(in_rt_id, in_rt_data, w_own_ok, r_reg_id_p1, r_data_p1,
                       fwd_valid, fwd_wen, fwd_t, fwd_reg_id, fwd_data);

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    w_acc_single = 1'b0;
    w_acc_multi  = 1'b0;
    w_x_finish   = 1'b0;
    xalu_start   = 1'b0;
    xalu_cancel  = 1'b0;
    busy         = (r_state != IDLE);

    in_ready     = w_advance && (r_state == IDLE) && !flush && !Clr;
    w_acc_single = in_valid && in_ready && !in_multi;
    w_acc_multi  = in_valid && in_ready && in_multi;
    xalu_start   = w_acc_multi;
    w_x_finish   = (r_state == WAIT_X) && xalu_done;

    case (r_state)
      IDLE:      if (w_acc_multi) w_state_nxt = WAIT_X;
      WAIT_X:    if (xalu_done) w_state_nxt = w_advance ? IDLE : DONE_HOLD;
      DONE_HOLD: if (w_advance) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase

    if (flush) begin
      w_state_nxt = IDLE;
      xalu_cancel = (r_state != IDLE);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Multicycle context; only meaningful while busy, so left unreset.
  always_ff @(posedge Clk) begin
    if (w_acc_multi) begin
      r_hold_wen     <= in_wen;
      r_hold_t       <= in_t;
      r_hold_reg_id  <= in_reg_id;
      r_hold_store   <= op_rt;
      r_hold_payload <= in_payload;
    end
    if (w_x_finish && !w_advance && !flush)
      r_hold_result <= xalu_result;
  end

  // Output register stage (p1)
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_valid_p1   <= 1'b0;
      r_wen_p1     <= 1'b0;
      r_t_p1       <= '0;
      r_reg_id_p1  <= '0;
      r_data_p1    <= '0;
      r_store_p1   <= '0;
      r_payload_p1 <= '0;
    end else if (flush) begin
      r_valid_p1 <= 1'b0;
      r_wen_p1   <= 1'b0;
      r_t_p1     <= '0;
    end else if (w_advance) begin
      if (w_acc_single) begin
        r_valid_p1   <= 1'b1;
        r_wen_p1     <= in_wen;
        r_t_p1       <= w_t_dec;
        r_reg_id_p1  <= in_reg_id;
        r_data_p1    <= alu_result;
        r_store_p1   <= op_rt;
        r_payload_p1 <= in_payload;
      end else if (w_x_finish || (r_state == DONE_HOLD)) begin
        r_valid_p1   <= 1'b1;
        r_wen_p1     <= r_hold_wen;
        r_t_p1       <= r_hold_t;
        r_reg_id_p1  <= r_hold_reg_id;
        r_data_p1    <= w_x_finish ? xalu_result : r_hold_result;
        r_store_p1   <= r_hold_store;
        r_payload_p1 <= r_hold_payload;
      end else begin
        r_valid_p1 <= 1'b0;
        r_wen_p1   <= 1'b0;
      end
    end
  end

  assign out_valid      = r_valid_p1;
  assign out_wen        = r_wen_p1;
  assign out_t          = r_t_p1;
  assign out_reg_id     = r_reg_id_p1;
  assign out_data       = r_data_p1;
  assign out_store_data = r_store_p1;
  assign out_payload    = r_payload_p1;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe: forwarding vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_exec_stage_pipe;
  localparam int DW = 32, RW = 5, TW = 4, NF = 2, PW = 64;

  logic Clk = 1'b0, Clr = 1'b1, flush = 1'b0;
  logic in_valid, in_ready, in_wen, in_multi;
  logic [RW-1:0] in_rs_id, in_rt_id, in_reg_id;
  logic [DW-1:0] in_rs_data, in_rt_data;
  logic [TW-1:0] in_t;
  logic [PW-1:0] in_payload;
  logic [NF-1:0] fwd_valid, fwd_wen;
  logic [NF*TW-1:0] fwd_t;
  logic [NF*RW-1:0] fwd_reg_id;
  logic [NF*DW-1:0] fwd_data;
  logic [DW-1:0] op_rs, op_rt, alu_result, xalu_result;
  logic xalu_start, xalu_cancel, xalu_done;
  logic out_valid, out_wen, out_ready, busy;
  logic [TW-1:0] out_t;
  logic [RW-1:0] out_reg_id;
  logic [DW-1:0] out_data, out_store_data;
  logic [PW-1:0] out_payload;

  exec_stage_pipe #(.DATA_W(DW), .REG_ID_W(RW), .T_W(TW), .NUM_FWD(NF), .PAYLOAD_W(PW)) dut (
    .Clk(Clk), .Clr(Clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_id(in_rs_id), .in_rt_id(in_rt_id), .in_reg_id(in_reg_id),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_t(in_t), .in_wen(in_wen),
    .in_multi(in_multi), .in_payload(in_payload), .fwd_valid(fwd_valid), .fwd_wen(fwd_wen),
    .fwd_t(fwd_t), .fwd_reg_id(fwd_reg_id), .fwd_data(fwd_data), .op_rs(op_rs), .op_rt(op_rt),
    .alu_result(alu_result), .xalu_start(xalu_start), .xalu_cancel(xalu_cancel),
    .xalu_done(xalu_done), .xalu_result(xalu_result), .out_valid(out_valid), .out_wen(out_wen),
    .out_ready(out_ready), .out_t(out_t), .out_reg_id(out_reg_id), .out_data(out_data),
    .out_store_data(out_store_data), .out_payload(out_payload), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic w, input logic [TW-1:0] t,
                         input logic [RW-1:0] id, input logic [DW-1:0] d);
    fwd_valid[k] = v;
    fwd_wen[k] = w;
    fwd_t[k*TW +: TW] = t;
    fwd_reg_id[k*RW +: RW] = id;
    fwd_data[k*DW +: DW] = d;
  endtask

  task automatic issue(input logic multi, input logic [RW-1:0] rid, input logic wen,
                       input logic [TW-1:0] t, input logic [DW-1:0] alu);
    in_valid = 1'b1;
    in_multi = multi;
    in_reg_id = rid;
    in_wen = wen;
    in_t = t;
    alu_result = alu;
  endtask

  typedef struct {
    logic [RW-1:0] rs_id, rt_id, id0, id1;
    logic [1:0]    fv, fw;
    logic [TW-1:0] t0, t1;
    logic [DW-1:0] e_rs, e_rt;
  } vec_t;
  vec_t vecs[8];

  // Behavioural model: pending/latched multicycle op plus visible output record.
  logic m_ov, m_ow, m_wait, m_held, h_wen;
  logic [TW-1:0] m_t, h_t;
  logic [RW-1:0] m_rid, h_rid;
  logic [DW-1:0] m_d, m_sd, h_sd, h_res;
  logic [PW-1:0] m_pay, h_pay;
  logic adv, idle, e_inr;
  logic [DW-1:0] e_rs, e_rt;

  function automatic logic [DW-1:0] m_fwd(input logic [RW-1:0] id, input logic [DW-1:0] rf);
    logic          hit [NF+1];
    logic [DW-1:0] dat [NF+1];
    if (id == 0) return rf;
    hit[0] = m_ov && m_ow && (m_t == 0) && (m_rid == id);
    dat[0] = m_d;
    for (int k = 0; k < NF; k++) begin
      hit[k+1] = fwd_valid[k] && fwd_wen[k] && (fwd_t[k*TW +: TW] == 0) && (fwd_reg_id[k*RW +: RW] == id);
      dat[k+1] = fwd_data[k*DW +: DW];
    end
    for (int k = 0; k <= NF; k++)
      if (hit[k]) return dat[k];
    return rf;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; in_multi = 0; in_wen = 0; in_rs_id = 0; in_rt_id = 0; in_reg_id = 0;
    in_rs_data = 0; in_rt_data = 0; in_t = 0; in_payload = 0; alu_result = 0;
    xalu_done = 0; xalu_result = 0; out_ready = 0;
    fwd_valid = 0; fwd_wen = 0; fwd_t = 0; fwd_reg_id = 0; fwd_data = 0;

    // Reset state
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_payload", out_payload, 0);
    chk("rst out_t", out_t, 0);
    chk("rst busy", busy, 0);
    chk("rst xalu_start", xalu_start, 0);
    tick();
    Clr = 0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // Forwarding table, output stage empty
    vecs[0] = '{rs_id:3, rt_id:4, id0:3, id1:4, fv:0, fw:0, t0:0, t1:0, e_rs:'h11, e_rt:'h22};
    vecs[1] = '{rs_id:3, rt_id:4, id0:3, id1:4, fv:3, fw:3, t0:0, t1:0, e_rs:'hA0, e_rt:'hB1};
    vecs[2] = '{rs_id:3, rt_id:4, id0:3, id1:3, fv:3, fw:3, t0:0, t1:0, e_rs:'hA0, e_rt:'h22};
    vecs[3] = '{rs_id:3, rt_id:4, id0:3, id1:3, fv:3, fw:2, t0:0, t1:0, e_rs:'hB1, e_rt:'h22};
    vecs[4] = '{rs_id:3, rt_id:4, id0:3, id1:3, fv:3, fw:3, t0:1, t1:0, e_rs:'hB1, e_rt:'h22};
    vecs[5] = '{rs_id:0, rt_id:0, id0:0, id1:0, fv:3, fw:3, t0:0, t1:0, e_rs:'h11, e_rt:'h22};
    vecs[6] = '{rs_id:3, rt_id:4, id0:3, id1:4, fv:2, fw:3, t0:0, t1:0, e_rs:'h11, e_rt:'hB1};
    vecs[7] = '{rs_id:4, rt_id:3, id0:3, id1:4, fv:3, fw:3, t0:0, t1:2, e_rs:'h11, e_rt:'hA0};
    in_rs_data = 'h11;
    in_rt_data = 'h22;
    for (int i = 0; i < 8; i++) begin
      in_rs_id = vecs[i].rs_id;
      in_rt_id = vecs[i].rt_id;
      set_fwd(0, vecs[i].fv[0], vecs[i].fw[0], vecs[i].t0, vecs[i].id0, 'hA0);
      set_fwd(1, vecs[i].fv[1], vecs[i].fw[1], vecs[i].t1, vecs[i].id1, 'hB1);
      #1;
      chk($sformatf("vec%0d op_rs", i), op_rs, vecs[i].e_rs);
      chk($sformatf("vec%0d op_rt", i), op_rt, vecs[i].e_rt);
    end
    fwd_valid = 0;
    in_rs_id = 0;
    in_rt_id = 0;

    // Own output register outranks fwd[0]
    issue(0, 3, 1, 0, 'hAA);
    tick();
    in_valid = 0;
    chk("own out_valid", out_valid, 1);
    chk("own out_data", out_data, 'hAA);
    chk("own out_reg_id", out_reg_id, 3);
    in_rs_id = 3;
    set_fwd(0, 1, 1, 0, 3, 'hBB);
    #1;
    chk("own beats fwd0", op_rs, 'hAA);
    in_rs_id = 0;
    in_rt_data = 'h55;
    out_ready = 1;
    issue(0, 3, 0, 0, 'hCC);
    tick();
    in_valid = 0;
    out_ready = 0;
    in_rs_id = 3;
    #1;
    chk("wen0 out_wen", out_wen, 0);
    chk("wen0 store", out_store_data, 'h55);
    chk("wen0 fwd0 wins", op_rs, 'hBB);
    fwd_valid = 0;
    in_rs_id = 0;

    // out_t countdown held under back-pressure
    out_ready = 1;
    issue(0, 6, 1, 2, 'h10);
    tick();
    in_valid = 0;
    out_ready = 0;
    chk("t2 out_t c0", out_t, 1);
    tick();
    chk("t2 out_t c1", out_t, 1);
    tick();
    chk("t2 out_t c2", out_t, 1);
    chk("t2 still valid", out_valid, 1);
    out_ready = 1;
    issue(0, 6, 1, 0, 'h11);
    #1;
    chk("t0 in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("t0 out_t", out_t, 0);

    // Multicycle op finishing under out_ready=0
    in_payload = 64'hFEED_0000_0000_0038;
    in_rt_data = 'h77;
    issue(1, 7, 1, 3, 'h0);
    #1;
    chk("multi xalu_start", xalu_start, 1);
    tick();
    in_valid = 0;
    in_multi = 0;
    out_ready = 0;
    chk("multi busy", busy, 1);
    chk("multi in_ready", in_ready, 0);
    chk("multi start pulse", xalu_start, 0);
    chk("multi out_valid", out_valid, 0);
    repeat (4) tick();
    chk("multi wait busy", busy, 1);
    xalu_done = 1;
    xalu_result = 'h1234;
    tick();
    xalu_done = 0;
    chk("xdone out_valid", out_valid, 1);
    chk("xdone out_data", out_data, 'h1234);
    chk("xdone out_reg_id", out_reg_id, 7);
    chk("xdone out_t", out_t, 3);
    chk("xdone store", out_store_data, 'h77);
    chk("xdone payload", out_payload, 64'hFEED_0000_0000_0038);
    chk("xdone in_ready", in_ready, 0);
    tick();
    chk("xdone held data", out_data, 'h1234);
    out_ready = 1;
    #1;
    chk("drain in_ready", in_ready, 1);
    tick();
    chk("drain out_valid", out_valid, 0);
    chk("drain busy", busy, 0);

    // Flush during WAIT_X, then a late xalu_done
    issue(1, 8, 1, 0, 'h0);
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    #1;
    chk("flush cancel", xalu_cancel, 1);
    chk("flush in_ready", in_ready, 0);
    tick();
    flush = 0;
    chk("flush out_valid", out_valid, 0);
    chk("flush busy", busy, 0);
    xalu_done = 1;
    xalu_result = 'h9999;
    tick();
    xalu_done = 0;
    chk("late done out_valid", out_valid, 0);
    chk("late done busy", busy, 0);
    // flush in IDLE: no start, no cancel
    issue(1, 8, 1, 0, 'h0);
    flush = 1;
    #1;
    chk("idle flush start", xalu_start, 0);
    chk("idle flush cancel", xalu_cancel, 0);
    tick();
    in_valid = 0;
    flush = 0;
    chk("idle flush busy", busy, 0);
    // flush clears a held output and its countdown
    out_ready = 0;
    issue(0, 9, 1, 3, 'h42);
    tick();
    in_valid = 0;
    chk("pre-flush out_t", out_t, 2);
    flush = 1;
    tick();
    flush = 0;
    chk("flush clr valid", out_valid, 0);
    chk("flush clr out_t", out_t, 0);

    // Asynchronous Clr pulse mid WAIT_X
    out_ready = 1;
    in_payload = 64'h1;
    issue(0, 5, 1, 2, 'hDEAD);
    tick();
    issue(1, 5, 1, 0, 'h0);
    tick();
    in_valid = 0;
    in_multi = 0;
    chk("pre-clr busy", busy, 1);
    chk("pre-clr out_data", out_data, 'hDEAD);
    Clr = 1;
    #1;
    chk("clr out_data", out_data, 0);
    chk("clr out_valid", out_valid, 0);
    chk("clr out_reg_id", out_reg_id, 0);
    chk("clr out_payload", out_payload, 0);
    chk("clr busy", busy, 0);
    chk("clr cancel", xalu_cancel, 0);
    chk("clr start", xalu_start, 0);
    Clr = 0;
    tick();
    xalu_done = 1;
    tick();
    xalu_done = 0;
    chk("post-clr done valid", out_valid, 0);
    chk("post-clr done busy", busy, 0);

    // Randomized run against the model
    Clr = 1;
    #1;
    Clr = 0;
    m_ov = 0; m_ow = 0; m_t = 0; m_rid = 0; m_d = 0; m_sd = 0; m_pay = 0;
    m_wait = 0; m_held = 0;
    h_wen = 0; h_t = 0; h_rid = 0; h_sd = 0; h_res = 0; h_pay = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_multi = ($urandom_range(0, 3) == 0);
      in_rs_id = $urandom_range(0, 3);
      in_rt_id = $urandom_range(0, 3);
      in_reg_id = $urandom_range(0, 3);
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_t = $urandom_range(0, 3);
      in_wen = $urandom_range(0, 1);
      in_payload = {$urandom, $urandom};
      alu_result = $urandom;
      xalu_result = $urandom;
      xalu_done = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NF; k++)
        set_fwd(k, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom);
      #1;
      adv = !m_ov || out_ready;
      idle = !m_wait && !m_held;
      e_inr = adv && idle && !flush;
      e_rs = m_fwd(in_rs_id, in_rs_data);
      e_rt = m_fwd(in_rt_id, in_rt_data);
      chk("rnd in_ready", in_ready, e_inr);
      chk("rnd op_rs", op_rs, e_rs);
      chk("rnd op_rt", op_rt, e_rt);
      chk("rnd xalu_start", xalu_start, in_valid && e_inr && in_multi);
      chk("rnd xalu_cancel", xalu_cancel, flush && !idle);
      chk("rnd busy", busy, !idle);
      if (flush) begin
        m_ov = 0; m_ow = 0; m_t = 0; m_wait = 0; m_held = 0;
      end else if (in_valid && e_inr && !in_multi) begin
        m_ov = 1; m_ow = in_wen; m_t = (in_t == 0) ? 0 : in_t - 1; m_rid = in_reg_id;
        m_d = alu_result; m_sd = e_rt; m_pay = in_payload;
      end else if (in_valid && e_inr && in_multi) begin
        h_wen = in_wen; h_t = in_t; h_rid = in_reg_id; h_sd = e_rt; h_pay = in_payload;
        m_wait = 1; m_ov = 0; m_ow = 0;
      end else if (m_wait && xalu_done) begin
        m_wait = 0;
        if (adv) begin
          m_ov = 1; m_ow = h_wen; m_t = h_t; m_rid = h_rid; m_d = xalu_result; m_sd = h_sd; m_pay = h_pay;
        end else begin
          m_held = 1; h_res = xalu_result;
        end
      end else if (m_held && adv) begin
        m_held = 0;
        m_ov = 1; m_ow = h_wen; m_t = h_t; m_rid = h_rid; m_d = h_res; m_sd = h_sd; m_pay = h_pay;
      end else if (adv) begin
        m_ov = 0; m_ow = 0;
      end
      tick();
      chk("rnd out_valid", out_valid, m_ov);
      chk("rnd out_wen", out_wen, m_ow);
      if (m_ov) begin
        chk("rnd out_data", out_data, m_d);
        chk("rnd out_t", out_t, m_t);
        chk("rnd out_reg_id", out_reg_id, m_rid);
        chk("rnd out_store", out_store_data, m_sd);
        chk("rnd out_payload", out_payload, m_pay);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
